iter_multdiv_unit: RTL

//  Iterative signed 32-bit multiply/divide unit for the execute stage of the 5-stage pipeline.
//  A one-cycle ctrl_MULT/ctrl_DIV pulse from X starts an operation on the bypassed ALU operands.
//  The unit runs a radix-4 Booth multiply or a non-restoring divide.
//  It then pulses data_resultRDY so the P/W latch can merge the result into M/W while stall control releases.

---
 rtl/iter_multdiv_if.sv | 31 +++
 rtl/iter_multdiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iter_multdiv_if.sv
// ---------------------------------------------------------------------------
// iter_multdiv_if
// Operand, start-control and result signals between the execute stage and
// the iterative multiply/divide unit.
//   data_operandA / data_operandB : multiplicand/dividend, multiplier/divisor
//   ctrl_MULT / ctrl_DIV          : one-cycle start pulses
//   data_result / data_exception  : registered result and overflow/div-by-zero
//   data_resultRDY                : one-cycle result-valid pulse
//   busy                          : operation in progress
// master = execute stage side, slave = the unit.
// ---------------------------------------------------------------------------
interface iter_multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/iter_multdiv_unit.sv
// ---------------------------------------------------------------------------
// iter_multdiv_unit
// Iterative signed 32-bit multiply (radix-4 Booth, 16 iterations) and
// divide (non-restoring on magnitudes, 32 iterations).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : iter_multdiv_if.slave (operands, start pulses, result, busy)
// A start pulse in any state aborts the current operation and restarts.
// Result/exception are registered and hold until the next result pulse.
// ---------------------------------------------------------------------------
module iter_multdiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MULT_ITERS = 16,
    parameter int DIV_ITERS  = 32
) (
    input logic           clock,
    input logic           reset,
    iter_multdiv_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MULT_ITERS - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    // Booth radix-4 partial product for one 3-bit window, sign-extended by one bit
    // so that +/-2M wraps consistently inside the accumulator.
    function automatic logic [WIDTH:0] booth_term(input logic [2:0] bits,
                                                  input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] m_ext;
        m_ext = {mcand[WIDTH-1], mcand};
        case (bits)
            3'b001, 3'b010: booth_term = m_ext;
            3'b011:         booth_term = m_ext << 1;
            3'b100:         booth_term = -(m_ext << 1);
            3'b101, 3'b110: booth_term = -m_ext;
            default:        booth_term = {(WIDTH+1){1'b0}};
        endcase
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    state_t               state_r, next_state_s;
    logic [5:0]           count_r;
    logic [2*WIDTH+1:0]   mul_r;      // {acc[32:0], multiplier[31:0], guard}
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH:0]       rem_r;      // signed partial remainder
    logic [WIDTH-1:0]     quo_r;      // dividend magnitude shifting into quotient
    logic [WIDTH-1:0]     dvsr_r;
    logic                 is_mul_r, q_neg_r, div_zero_r, div_ovf_r;
    logic [WIDTH-1:0]     result_r;
    logic                 exc_r, rdy_r, busy_r;

    logic                 start_s;
    logic [WIDTH:0]       acc_sum_s;
    logic [2*WIDTH+1:0]   mul_step_s;
    logic [WIDTH:0]       rem_shift_s, rem_step_s;
    logic [WIDTH-1:0]     quo_step_s;
    logic [2*WIDTH-1:0]   product_s;
    logic                 mul_exc_s;
    logic [WIDTH-1:0]     div_result_s;

    assign start_s = bus.ctrl_MULT | bus.ctrl_DIV;

    // One iteration of each datapath plus result formatting for the DONE cycle.
    always_comb begin
        acc_sum_s    = mul_r[2*WIDTH+1:WIDTH+1] + booth_term(mul_r[2:0], mcand_r);
        mul_step_s   = $signed({acc_sum_s, mul_r[WIDTH:0]}) >>> 2;
        rem_shift_s  = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        if (rem_r[WIDTH]) begin
            rem_step_s = rem_shift_s + {1'b0, dvsr_r};
        end else begin
            rem_step_s = rem_shift_s - {1'b0, dvsr_r};
        end
        quo_step_s   = {quo_r[WIDTH-2:0], ~rem_step_s[WIDTH]};
        product_s    = mul_r[2*WIDTH:1];
        // Fits in WIDTH bits only if the upper half and bit WIDTH-1 all agree.
        mul_exc_s    = ~((&product_s[2*WIDTH-1:WIDTH-1]) | ~(|product_s[2*WIDTH-1:WIDTH-1]));
        if (div_zero_r) begin
            div_result_s = {WIDTH{1'b0}};
        end else if (q_neg_r) begin
            div_result_s = -quo_r;
        end else begin
            div_result_s = quo_r;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a start pulse wins in every state, multiply over divide.
    always_comb begin
        next_state_s = state_r;
        if (bus.ctrl_MULT) begin
            next_state_s = ST_MUL;
        end else if (bus.ctrl_DIV) begin
            next_state_s = ST_DIV;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = ST_IDLE;
                ST_MUL:  next_state_s = (count_r == MUL_LAST) ? ST_DONE : ST_MUL;
                ST_DIV:  next_state_s = (count_r == DIV_LAST) ? ST_DONE : ST_DIV;
                ST_DONE: next_state_s = ST_IDLE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath, iteration counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r    <= 6'd0;
            mul_r      <= {(2*WIDTH+2){1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            dvsr_r     <= {WIDTH{1'b0}};
            is_mul_r   <= 1'b0;
            q_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
            div_ovf_r  <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            exc_r      <= 1'b0;
            rdy_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else if (start_s) begin
            // Both datapaths are loaded; only the selected one is stepped.
            count_r    <= 6'd0;
            mul_r      <= {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
            mcand_r    <= bus.data_operandA;
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= magnitude(bus.data_operandA);
            dvsr_r     <= magnitude(bus.data_operandB);
            is_mul_r   <= bus.ctrl_MULT;
            q_neg_r    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div_zero_r <= (bus.data_operandB == {WIDTH{1'b0}});
            div_ovf_r  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (bus.data_operandB == {WIDTH{1'b1}});
            rdy_r      <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            rdy_r <= 1'b0;
            case (state_r)
                ST_MUL: begin
                    mul_r   <= mul_step_s;
                    count_r <= count_r + 6'd1;
                end
                ST_DIV: begin
                    rem_r   <= rem_step_s;
                    quo_r   <= quo_step_s;
                    count_r <= count_r + 6'd1;
                end
                ST_DONE: begin
                    result_r <= is_mul_r ? product_s[WIDTH-1:0] : div_result_s;
                    exc_r    <= is_mul_r ? mul_exc_s : (div_zero_r | div_ovf_r);
                    rdy_r    <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign bus.data_result    = result_r;
    assign bus.data_exception = exc_r;
    assign bus.data_resultRDY = rdy_r;
    assign bus.busy           = busy_r;

endmodule
